// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, sticky
// overflow/underflow flags and either registered-read or first-word-fall-through output.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   wr,
  input  logic [DATA_W-1:0]      DB,
  input  logic                   rd,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              write_ok, read_ok;

  // Handshake: a write is taken on any edge with wr=1 unless the FIFO is full
  // and no pop happens on that same edge; a read is taken on any edge with
  // rd=1 while not empty. Rejected requests leave storage, pointers and dout alone.
  always_comb begin
    write_ok = wr & (~full_q | rd);
    read_ok  = rd & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (write_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (read_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    count_d  = count_q + CW'(write_ok) - CW'(read_ok);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));

    dout_d = dout_q;
    if (FWFT != 0) begin
      // Present the head-of-queue word; bypass DB when the head is being written now.
      if (count_d != '0)
        dout_d = (write_ok && (wr_ptr_q == rd_ptr_d)) ? DB : mem_q[rd_ptr_d];
    end else if (read_ok) begin
      dout_d = mem_q[rd_ptr_q];
    end

    // A new error on the same edge as clr_err wins over the clear.
    ovf_d = (ovf_q & ~clr_err) | (wr & full_q & ~rd);
    udf_d = (udf_q & ~clr_err) | (rd & empty_q);
  end

  always_ff @(posedge Clk) begin
    if (write_ok) mem_q[wr_ptr_q] <= DB;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign dout         = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a 64-deep standard-read instance and an
// 8-deep first-word-fall-through instance sharing clock and reset.
module tb_sync_fifo_param;

  logic       Clk;
  logic       Rst;
  logic       wr, rd, clr_err;
  logic [7:0] DB;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [6:0] count;

  logic       f_wr, f_rd, f_clr_err;
  logic [7:0] f_DB;
  logic [7:0] f_dout;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(64), .AFULL_TH(60), .AEMPTY_TH(4), .FWFT(0)) dut (
    .Clk(Clk), .Rst(Rst), .wr(wr), .DB(DB), .rd(rd), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) dut_fwft (
    .Clk(Clk), .Rst(Rst), .wr(f_wr), .DB(f_DB), .rd(f_rd), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow), .clr_err(f_clr_err)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; wr = 0; rd = 0; clr_err = 0; DB = '0;
    f_wr = 0; f_rd = 0; f_clr_err = 0; f_DB = '0;
    tick(); tick();
    vec_cnt++;
    if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || dout !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: cnt=%0d e=%b f=%b ae=%b af=%b dout=%h ovf=%b udf=%b, required 0 1 0 1 0 00 0 0",
               count, empty, full, almost_empty, almost_full, dout, overflow, underflow);
    end
    vec_cnt++;
    if (f_empty !== 1'b1 || f_dout !== 8'h00 || f_count !== 4'd0) begin
      err_cnt++;
      $display("FAIL fwft_reset_state: e=%b dout=%h cnt=%0d, required 1 00 0", f_empty, f_dout, f_count);
    end
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 64; i++) begin
      wr = 1; DB = 8'(i);
      tick();
      vec_cnt++;
      if (count !== 7'(i) || almost_full !== (i >= 60) || full !== (i == 64) ||
          almost_empty !== (i <= 4) || empty !== 1'b0) begin
        err_cnt++;
        $display("FAIL fill_%0d: cnt=%0d af=%b f=%b ae=%b e=%b, required cnt=%0d af=%b f=%b ae=%b e=0",
                 i, count, almost_full, full, almost_empty, empty, i, i >= 60, i == 64, i <= 4);
      end
    end
    wr = 0;
    vec_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL fill_overflow: got %b, required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    wr = 1; DB = 8'hAA;
    tick();
    wr = 0;
    vec_cnt++;
    if (count !== 7'd64 || overflow !== 1'b1 || full !== 1'b1) begin
      err_cnt++;
      $display("FAIL overflow_set: cnt=%0d ovf=%b f=%b, required 64 1 1", count, overflow, full);
    end
    clr_err = 1;
    tick();
    clr_err = 0;
    vec_cnt++;
    if (overflow !== 1'b0 || count !== 7'd64) begin
      err_cnt++;
      $display("FAIL overflow_clear: ovf=%b cnt=%0d, required 0 64", overflow, count);
    end
  endtask

  task automatic test_drain_in_order();
    for (int k = 1; k <= 64; k++) begin
      rd = 1;
      tick();
      vec_cnt++;
      if (dout !== 8'(k) || count !== 7'(64 - k) || almost_empty !== ((64 - k) <= 4)) begin
        err_cnt++;
        $display("FAIL drain_%0d: dout=%h cnt=%0d ae=%b, required dout=%h cnt=%0d ae=%b",
                 k, dout, count, almost_empty, 8'(k), 64 - k, (64 - k) <= 4);
      end
    end
    rd = 0;
    vec_cnt++;
    if (empty !== 1'b1 || full !== 1'b0 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_end: e=%b f=%b udf=%b, required 1 0 0", empty, full, underflow);
    end
  endtask

  task automatic test_underflow();
    rd = 1;
    tick();
    rd = 0;
    vec_cnt++;
    if (underflow !== 1'b1 || dout !== 8'd64 || count !== 7'd0 || empty !== 1'b1) begin
      err_cnt++;
      $display("FAIL underflow_set: udf=%b dout=%h cnt=%0d e=%b, required 1 40 0 1",
               underflow, dout, count, empty);
    end
    clr_err = 1;
    tick();
    clr_err = 0;
    vec_cnt++;
    if (underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL underflow_clear: got %b, required 0", underflow);
    end
    wr = 1; rd = 1; DB = 8'h5A;
    tick();
    wr = 0; rd = 0;
    vec_cnt++;
    if (count !== 7'd1 || underflow !== 1'b1 || empty !== 1'b0 || dout !== 8'd64) begin
      err_cnt++;
      $display("FAIL wr_rd_on_empty: cnt=%0d udf=%b e=%b dout=%h, required 1 1 0 40",
               count, underflow, empty, dout);
    end
    rd = 1;
    tick();
    rd = 0; clr_err = 1;
    tick();
    clr_err = 0;
    vec_cnt++;
    if (dout !== 8'h5A || count !== 7'd0 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL read_after_wr_rd: dout=%h cnt=%0d udf=%b, required 5a 0 0", dout, count, underflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 64; i++) begin
      wr = 1; DB = 8'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      wr = 1; rd = 1; DB = 8'(100 + k);
      tick();
      vec_cnt++;
      if (count !== 7'd64 || overflow !== 1'b0 || full !== 1'b1 || dout !== 8'(k + 1)) begin
        err_cnt++;
        $display("FAIL b2b_%0d: cnt=%0d ovf=%b f=%b dout=%h, required 64 0 1 %h",
                 k, count, overflow, full, dout, 8'(k + 1));
      end
    end
    wr = 0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] exp_v;
      exp_v = (i < 54) ? 8'(11 + i) : 8'(100 + i - 54);
      rd = 1;
      tick();
      vec_cnt++;
      if (dout !== exp_v) begin
        err_cnt++;
        $display("FAIL wrap_drain_%0d: dout=%h, required %h", i, dout, exp_v);
      end
    end
    rd = 0;
    vec_cnt++;
    if (empty !== 1'b1 || count !== 7'd0) begin
      err_cnt++;
      $display("FAIL wrap_end: e=%b cnt=%0d, required 1 0", empty, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      wr = 1; DB = 8'(8'h40 + k);
      tick();
    end
    DB = 8'h45;
    Rst = 1'b0;
    #2;
    vec_cnt++;
    if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || dout !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: cnt=%0d e=%b f=%b ae=%b af=%b dout=%h ovf=%b udf=%b, required 0 1 0 1 0 00 0 0",
               count, empty, full, almost_empty, almost_full, dout, overflow, underflow);
    end
    tick();
    wr = 0;
    Rst = 1'b1;
    tick();
    wr = 1; DB = 8'h33;
    tick();
    wr = 0;
    vec_cnt++;
    if (count !== 7'd1) begin
      err_cnt++;
      $display("FAIL post_reset_write: cnt=%0d, required 1", count);
    end
    rd = 1;
    tick();
    rd = 0;
    vec_cnt++;
    if (dout !== 8'h33 || count !== 7'd0) begin
      err_cnt++;
      $display("FAIL post_reset_read: dout=%h cnt=%0d, required 33 0", dout, count);
    end
  endtask

  task automatic test_fwft();
    f_wr = 1; f_DB = 8'h11;
    tick();
    f_wr = 0;
    vec_cnt++;
    if (f_empty !== 1'b0 || f_dout !== 8'h11) begin
      err_cnt++;
      $display("FAIL fwft_first_word: e=%b dout=%h, required 0 11", f_empty, f_dout);
    end
    f_wr = 1; f_DB = 8'h22;
    tick();
    f_wr = 0;
    vec_cnt++;
    if (f_dout !== 8'h11 || f_count !== 4'd2) begin
      err_cnt++;
      $display("FAIL fwft_head_hold: dout=%h cnt=%0d, required 11 2", f_dout, f_count);
    end
    f_rd = 1;
    tick();
    vec_cnt++;
    if (f_dout !== 8'h22 || f_count !== 4'd1) begin
      err_cnt++;
      $display("FAIL fwft_pop: dout=%h cnt=%0d, required 22 1", f_dout, f_count);
    end
    tick();
    f_rd = 0;
    vec_cnt++;
    if (f_empty !== 1'b1 || f_dout !== 8'h22 || f_underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL fwft_empty_hold: e=%b dout=%h udf=%b, required 1 22 0", f_empty, f_dout, f_underflow);
    end
    f_wr = 1; f_DB = 8'h33;
    tick();
    f_DB = 8'h44; f_rd = 1;
    tick();
    f_wr = 0; f_rd = 0;
    vec_cnt++;
    if (f_dout !== 8'h44 || f_count !== 4'd1 || f_empty !== 1'b0) begin
      err_cnt++;
      $display("FAIL fwft_bypass: dout=%h cnt=%0d e=%b, required 44 1 0", f_dout, f_count, f_empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_in_order();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_fwft();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
